// File: rtl/operand_memory.sv
// operand_memory: data-side responder for the soft CPU control matrix.
// Serves operand reads with a one-cycle request/valid handshake and commits
// result writes. Holds 2^ADDR_WIDTH-1 operand bytes; the all-ones address is
// the ACC alias and is never backed by storage.
//
// Ports:
//   clock, reset          single rising-edge clock, async active-high reset
//   ready                 high when requests are accepted
//   readReq/readAddy      read request strobe and address
//   readValid/readData    one-cycle result pulse and held result value
//   readErr               qualifies readValid: read hit the reserved address
//   writeReq/writeAddy/writeData  write request, committed at the accepting edge
//   writeErr              one-cycle pulse: write to reserved address dropped
//
// Configuration macro: OPERAND_MEM_CLEAR_EN
//   defined   -> CLEAR state zeroes storage after reset (255 cycles, ready=0)
//   undefined -> resets straight to IDLE, storage undefined until written
module operand_memory #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  readReq,
  input  logic [ADDR_WIDTH-1:0] readAddy,
  output logic                  readValid,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readErr,
  input  logic                  writeReq,
  input  logic [ADDR_WIDTH-1:0] writeAddy,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeErr
);

  localparam int unsigned DEPTH = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] RSVD_ADDR = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef OPERAND_MEM_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = RSVD_ADDR - ADDR_WIDTH'(1);
  logic [ADDR_WIDTH-1:0] clr_cnt;
`endif

  // Request qualification; requests outside ready are silently ignored.
  logic rd_acc_c;
  logic rd_rsvd_c;
  logic wr_acc_c;
  logic wr_rsvd_c;
  logic bypass_c;

  assign rd_acc_c  = ready & readReq;
  assign rd_rsvd_c = (readAddy == RSVD_ADDR);
  assign wr_rsvd_c = (writeAddy == RSVD_ADDR);
  assign wr_acc_c  = ready & writeReq & ~wr_rsvd_c;
  assign bypass_c  = wr_acc_c & (writeAddy == readAddy);

  // Storage: clear walk owns the array while not ready, user writes after.
  always_ff @(posedge clock) begin
`ifdef OPERAND_MEM_CLEAR_EN
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc_c) begin
      mem[writeAddy] <= writeData;
    end
`else
    if (wr_acc_c) begin
      mem[writeAddy] <= writeData;
    end
`endif
  end

  // Control FSM and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
`ifdef OPERAND_MEM_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      ready     <= 1'b0;
      readValid <= 1'b0;
      readData  <= '0;
      readErr   <= 1'b0;
      writeErr  <= 1'b0;
    end else begin
      case (state)
`ifdef OPERAND_MEM_CLEAR_EN
        CLEAR: begin
          // Counter stops at all-ones minus one; it never wraps.
          if (clr_cnt == LAST_ADDR) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase

      readValid <= rd_acc_c;
      readErr   <= rd_acc_c & rd_rsvd_c;
      writeErr  <= ready & writeReq & wr_rsvd_c;

      // Reserved reads return zero; same-address write wins over storage.
      if (rd_acc_c) begin
        if (rd_rsvd_c) begin
          readData <= '0;
        end else if (bypass_c) begin
          readData <= writeData;
        end else begin
          readData <= mem[readAddy];
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_memory.sv
// Self-checking bench for operand_memory: randomized and directed traffic
// checked against an array model of the operand storage.
module tb_operand_memory;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam logic [7:0] RSVD = 8'hFF;
`ifdef OPERAND_MEM_CLEAR_EN
  localparam int CLR = 255;
`else
  localparam int CLR = 1;
`endif

  logic          clock;
  logic          reset;
  logic          ready;
  logic          readReq;
  logic [AW-1:0] readAddy;
  logic          readValid;
  logic [DW-1:0] readData;
  logic          readErr;
  logic          writeReq;
  logic [AW-1:0] writeAddy;
  logic [DW-1:0] writeData;
  logic          writeErr;

  operand_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .ready     (ready),
    .readReq   (readReq),
    .readAddy  (readAddy),
    .readValid (readValid),
    .readData  (readData),
    .readErr   (readErr),
    .writeReq  (writeReq),
    .writeAddy (writeAddy),
    .writeData (writeData),
    .writeErr  (writeErr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  int         checks = 0;
  int         errors = 0;
  logic       exp_ready;
  logic [7:0] exp_data;
  logic [7:0] model [0:255];

  task automatic model_zero();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // One clock of traffic; expectation derived from the storage model.
  task automatic do_cycle(input logic rd, input logic [7:0] ra, input logic wr,
                          input logic [7:0] wa, input logic [7:0] wd, input string tag);
    logic acc_r, acc_w, ee, ew;
    acc_r = exp_ready && rd;
    acc_w = exp_ready && wr;
    if (acc_r) begin
      if (ra == RSVD)              exp_data = 8'h00;
      else if (acc_w && wa == ra)  exp_data = wd;
      else                         exp_data = model[ra];
    end
    ee = acc_r && (ra == RSVD);
    ew = acc_w && (wa == RSVD);
    if (acc_w && wa != RSVD) model[wa] = wd;
    readReq = rd; readAddy = ra; writeReq = wr; writeAddy = wa; writeData = wd;
    @(posedge clock); #1;
    readReq = 1'b0; writeReq = 1'b0;
    checks++;
    if (readValid !== acc_r) begin
      errors++; $display("FAIL %s readValid: got %b expected %b", tag, readValid, acc_r);
    end
    checks++;
    if (readData !== exp_data) begin
      errors++; $display("FAIL %s readData: got %h expected %h", tag, readData, exp_data);
    end
    checks++;
    if (readErr !== ee) begin
      errors++; $display("FAIL %s readErr: got %b expected %b", tag, readErr, ee);
    end
    checks++;
    if (writeErr !== ew) begin
      errors++; $display("FAIL %s writeErr: got %b expected %b", tag, writeErr, ew);
    end
    checks++;
    if (ready !== exp_ready) begin
      errors++; $display("FAIL %s ready: got %b expected %b", tag, ready, exp_ready);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({ready, readValid, readData, readErr, writeErr} !== 12'h000) begin
      errors++;
      $display("FAIL %s outputs: got rdy=%b v=%b d=%h e=%b we=%b expected all zero",
               tag, ready, readValid, readData, readErr, writeErr);
    end
  endtask

  // Asserts reset asynchronously (mid-cycle) and holds it for a few edges.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero_outputs(tag);
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs({tag, "_held"});
    reset = 1'b0;
    readReq = 1'b0; writeReq = 1'b0;
    exp_ready = 1'b0;
    exp_data  = 8'h00;
  endtask

  // n edges after reset release with ignored random traffic; ready expected from edge ready_at.
  task automatic run_clear(input int n, input int ready_at, input string tag);
    logic exp_r;
    for (int k = 1; k <= n; k++) begin
      readReq   = 1'($urandom_range(0, 1));
      readAddy  = 8'($urandom_range(0, 255));
      writeReq  = 1'($urandom_range(0, 1));
      writeAddy = 8'($urandom_range(0, 254));
      writeData = 8'($urandom_range(1, 255));
      @(posedge clock); #1;
      exp_r = (k >= ready_at);
      checks++;
      if (ready !== exp_r || readValid !== 1'b0 || writeErr !== 1'b0 || readErr !== 1'b0) begin
        errors++;
        $display("FAIL %s edge %0d: got rdy=%b v=%b e=%b we=%b expected rdy=%b v=0 e=0 we=0",
                 tag, k, ready, readValid, readErr, writeErr, exp_r);
      end
    end
    readReq = 1'b0; writeReq = 1'b0;
    exp_ready = (n >= ready_at);
  endtask

  task automatic test_reset();
    apply_reset("reset");
    run_clear(CLR, CLR, "reset_ready");
`ifdef OPERAND_MEM_CLEAR_EN
    model_zero();
`endif
  endtask

  task automatic test_init_reads();
`ifndef OPERAND_MEM_CLEAR_EN
    for (int a = 0; a < 255; a++) do_cycle(1'b0, 8'h00, 1'b1, 8'(a), 8'h00, "init_wr");
`endif
    do_cycle(1'b1, 8'h00, 1'b0, 8'h00, 8'h00, "clr_rd00");
    do_cycle(1'b1, 8'h7F, 1'b0, 8'h00, 8'h00, "clr_rd7f");
    do_cycle(1'b1, 8'hFE, 1'b0, 8'h00, 8'h00, "clr_rdfe");
  endtask

  task automatic test_write_read();
    do_cycle(1'b0, 8'h00, 1'b1, 8'h10, 8'h5A, "wr10");
    do_cycle(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, "rd10");
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, "rd10_idle");
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b0, 8'h00, 1'b1, 8'h01, 8'h11, "pre1");
    do_cycle(1'b0, 8'h00, 1'b1, 8'h02, 8'h22, "pre2");
    do_cycle(1'b0, 8'h00, 1'b1, 8'h03, 8'h33, "pre3");
    do_cycle(1'b1, 8'h01, 1'b0, 8'h00, 8'h00, "b2b1");
    do_cycle(1'b1, 8'h02, 1'b0, 8'h00, 8'h00, "b2b2");
    do_cycle(1'b1, 8'h03, 1'b0, 8'h00, 8'h00, "b2b3");
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, "b2b_end");
  endtask

  task automatic test_bypass();
    do_cycle(1'b1, 8'h20, 1'b1, 8'h20, 8'hC3, "bypass");
    do_cycle(1'b1, 8'h20, 1'b1, 8'h21, 8'h44, "diff_addr");
    do_cycle(1'b1, 8'h21, 1'b0, 8'h00, 8'h00, "diff_addr_rd");
  endtask

  task automatic test_reserved();
    do_cycle(1'b0, 8'h00, 1'b1, RSVD, 8'h99, "wr_rsvd");
    do_cycle(1'b1, RSVD, 1'b0, 8'h00, 8'h00, "rd_rsvd");
    do_cycle(1'b1, RSVD, 1'b1, RSVD, 8'h77, "rw_rsvd");
    do_cycle(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, "rsvd_idle");
  endtask

  task automatic test_reset_mid();
    // In-flight valid and writeErr dropped by an async reset.
    do_cycle(1'b1, 8'h10, 1'b1, RSVD, 8'h12, "inflight");
    readReq = 1'b1; readAddy = 8'h10;
    apply_reset("reset_inflight");
`ifdef OPERAND_MEM_CLEAR_EN
    run_clear(100, CLR + 1, "clear_partial");
    readReq = 1'b1; readAddy = 8'h10;
    apply_reset("reset_midclear");
    run_clear(CLR, CLR, "clear_restart");
    model_zero();
`else
    run_clear(CLR, CLR, "restart");
`endif
    do_cycle(1'b1, 8'h10, 1'b0, 8'h00, 8'h00, "after_reset_rd");
    do_cycle(1'b1, 8'h01, 1'b0, 8'h00, 8'h00, "after_reset_rd1");
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? RSVD : 8'(8'h30 + r);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 1)), pick_addr(), 1'($urandom_range(0, 1)),
               pick_addr(), 8'($urandom_range(0, 255)), "random");
    end
  endtask

  initial begin
    reset = 1'b1; readReq = 1'b0; readAddy = '0;
    writeReq = 1'b0; writeAddy = '0; writeData = '0;
    exp_ready = 1'b0; exp_data = 8'h00;
    model_zero();
    test_reset();
    test_init_reads();
    test_write_read();
    test_back_to_back();
    test_bypass();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_memory.md
# operand_memory

Data-side responder for the soft CPU control matrix. Serves the operand fetches the control matrix issues when an instruction's address flag is set, and commits its result writes. Holds 255 bytes of operand storage; address 0xFF is reserved as the ACC alias and is never backed by storage. It sits between the control matrix and the board-level debug logic, replacing the free-running `valueGetter`/`valueGot` pair with an explicit request/valid handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width in bits.
- `ADDR_WIDTH`, 8, address width; storage depth is 2^ADDR_WIDTH − 1 and the all-ones address is reserved.

Ports:
- `clock`  input  1  single clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `ready`  output  1  high when requests are accepted.
- `readReq`  input  1  read request strobe, sampled on the rising edge of `clock`.
- `readAddy`  input  ADDR_WIDTH  read address.
- `readValid`  output  1  one-cycle pulse: `readData` carries the requested value.
- `readData`  output  DATA_WIDTH  read result; held until the next `readValid`.
- `readErr`  output  1  qualifies `readValid`: the read targeted the reserved address.
- `writeReq`  input  1  write request strobe.
- `writeAddy`  input  ADDR_WIDTH  write address.
- `writeData`  input  DATA_WIDTH  write value.
- `writeErr`  output  1  one-cycle pulse: the accepted write targeted the reserved address and was dropped.

## Operation
- States: CLEAR, IDLE.
  - CLEAR: an internal counter walks addresses 0x00..0xFE and writes 0x00 to each, one per cycle (255 cycles). `ready` = 0.
  - After the counter reaches 0xFE, the block enters IDLE. `ready` = 1.
- Requests are accepted only while `ready` = 1. Requests presented while `ready` = 0 are ignored: not queued and not flagged.
- Read: accepted at edge N, the stored value appears with `readValid` = 1 after edge N+1. `readErr` = `readValid` AND (address == all-ones). For an error read, `readData` = 0.
- Reads are fully pipelined: a new read may be accepted on every cycle, and `readValid` stays high continuously.
- Write: accepted at edge N and committed to storage at that same edge. A write to the all-ones address does not change storage and pulses `writeErr` for the following cycle.
- Simultaneous read and write to the same non-reserved address in one cycle: the read returns the new `writeData` (write-first bypass).
- Simultaneous read and write to different addresses: both complete independently.
- Address arithmetic: the CLEAR counter is ADDR_WIDTH bits and stops at all-ones − 1. It never wraps.

## Timing
- Reset values: `ready` = 0, `readValid` = 0, `readData` = 0, `readErr` = 0, `writeErr` = 0, state = CLEAR, counter = 0. Storage contents are not reset directly; CLEAR rewrites them.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously).
  - Any in-flight `readValid` is dropped.
  - CLEAR restarts from 0x00 when reset deasserts.
- Read latency: 1 cycle. Write latency: 0 cycles; the written value is visible to a read accepted on the next edge.
- The first accepted request arrives no earlier than 255 cycles after reset deassertion (with clear enabled).

## Configuration
- `OPERAND_MEM_CLEAR_EN`:
  - Defined: the CLEAR state exists as described.
  - Undefined: the block resets directly into IDLE, `ready` = 1 on the first edge after reset, and storage contents are undefined (X in simulation) until written.
  - All other behaviour is identical in both cases.

## Test plan
- With clear enabled, deassert reset. `ready` must rise exactly 255 cycles later. Then read 0x00, 0x7F and 0xFE: each returns `readData` = 0x00 with `readErr` = 0.
- Write 0x5A to 0x10, then read 0x10 on the next cycle. `readValid` must pulse one cycle after the read request with `readData` = 0x5A.
- Issue reads to 0x01, 0x02 and 0x03 on consecutive cycles (preloaded with 0x11, 0x22, 0x33). `readValid` must stay high for 3 cycles with `readData` = 0x11, 0x22, 0x33 in order.
- In the same cycle, write 0xC3 to 0x20 and read 0x20. The read must return 0xC3.
- Write 0x99 to 0xFF. `writeErr` must pulse once. A following read of 0xFF must give `readErr` = 1 and `readData` = 0x00.
- Assert reset 100 cycles into CLEAR with a pending read. All outputs must go to 0 immediately, and `ready` must rise 255 cycles after the reset is released. Also exercise a `readReq` with `ready` = 0: no `readValid` may be produced.
